// File: rtl/fetch_unit_mw.sv
// fetch_unit_mw: multi-wide instruction fetch stage with a loadable instruction memory,
// branch redirect/flush, stall and program-end detection. Define FETCH_PERF_EN for perf counters.
module fetch_unit_mw #(
    parameter int INSTR_W  = 32,
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 1024,
    parameter int FETCH_W  = 2,
    parameter int START_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_en,
    input  logic [ADDR_W-1:0]          load_addr,
    input  logic [INSTR_W-1:0]         load_data,
    input  logic                       start,
    input  logic                       stall,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       fetch_valid,
    output logic [ADDR_W-1:0]          fetch_pc,
    output logic [FETCH_W*INSTR_W-1:0] fetch_instr,
    output logic [FETCH_W-1:0]         slot_valid,
    output logic [ADDR_W:0]            prog_end,
    output logic                       done
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                perf_bundles,
    output logic [31:0]                perf_stall
`endif
);

    localparam int AW1 = ADDR_W + 1;
    localparam logic [AW1-1:0] PC0     = AW1'(START_PC);
    localparam logic [AW1-1:0] DEPTH_L = AW1'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

    state_t                      state;
    logic [INSTR_W-1:0]          mem [DEPTH];
    logic [AW1-1:0]              pc;
    logic                        load_ok;
    logic [AW1-1:0]              load_top;
    logic [AW1-1:0]              pe_nxt;
    logic [AW1-1:0]              pc_adv;
    logic [AW1-1:0]              rd_pc;
    logic [FETCH_W-1:0][AW1-1:0] slot_addr;
    logic [FETCH_W*INSTR_W-1:0]  rd_instr;
    logic [FETCH_W-1:0]          rd_valid;

    assign load_ok  = (state == S_IDLE) && load_en && ({1'b0, load_addr} < DEPTH_L);
    assign load_top = {1'b0, load_addr} + AW1'(1);
    assign pe_nxt   = (load_ok && load_top > prog_end) ? load_top : prog_end;
    assign pc_adv   = pc + AW1'(FETCH_W);
    assign rd_pc    = {1'b0, redirect_pc};

    // Slot k sits in the k-th most-significant lane of both the bundle and the valid mask.
    // Addresses are one bit wider than the memory index, so nothing wraps past the top.
    always_comb begin
        slot_addr = '0;
        rd_instr  = '0;
        rd_valid  = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            slot_addr[k] = pc + AW1'(k);
            if (slot_addr[k] < prog_end) begin
                rd_valid[FETCH_W-1-k] = 1'b1;
                rd_instr[(FETCH_W-1-k)*INSTR_W +: INSTR_W] = mem[slot_addr[k][ADDR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_ok)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= PC0;
            prog_end    <= '0;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            fetch_instr <= '0;
            slot_valid  <= '0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    fetch_valid <= 1'b0;
                    done        <= 1'b0;
                    prog_end    <= pe_nxt;
                    if (start) begin
                        pc    <= PC0;
                        state <= (pe_nxt == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    done <= 1'b0;
                    if (redirect_valid) begin
                        fetch_valid <= 1'b0;
                        slot_valid  <= '0;
                        pc          <= rd_pc;
                        if (rd_pc >= prog_end)
                            state <= S_DONE;
                    end else if (stall) begin
                        fetch_valid <= 1'b0;
                    end else begin
                        fetch_valid <= 1'b1;
                        fetch_pc    <= pc[ADDR_W-1:0];
                        fetch_instr <= rd_instr;
                        slot_valid  <= rd_valid;
                        pc          <= pc_adv;
                        if (pc_adv >= prog_end)
                            state <= S_DONE;
                    end
                end
                S_DONE: begin
                    fetch_valid <= 1'b0;
                    done        <= 1'b1;
                    if (redirect_valid) begin
                        slot_valid <= '0;
                        pc         <= rd_pc;
                        if (rd_pc < prog_end) begin
                            state <= S_FETCH;
                            done  <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bundles <= '0;
            perf_stall   <= '0;
        end else if (state == S_IDLE && start) begin
            perf_bundles <= '0;
            perf_stall   <= '0;
        end else begin
            if (fetch_valid && !(&perf_bundles))
                perf_bundles <= perf_bundles + 32'd1;
            if (state == S_FETCH && stall && !redirect_valid && !(&perf_stall))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit_mw.sv
// Self-checking bench for fetch_unit_mw: directed table, corner-case sequences and
// randomized traffic against a bundle-level reference model.
module tb_fetch_unit_mw;

    localparam int IW = 32, AW = 10, DEPTH = 1024, FW = 2, SPC = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_en = 1'b0;
    logic [AW-1:0]     load_addr = '0;
    logic [IW-1:0]     load_data = '0;
    logic              start = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
    logic [AW-1:0]     redirect_pc = '0;
    logic              fetch_valid, done;
    logic [AW-1:0]     fetch_pc;
    logic [FW*IW-1:0]  fetch_instr;
    logic [FW-1:0]     slot_valid;
    logic [AW:0]       prog_end;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_bundles, perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_unit_mw #(.INSTR_W(IW), .ADDR_W(AW), .DEPTH(DEPTH), .FETCH_W(FW), .START_PC(SPC)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .start(start), .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .slot_valid(slot_valid), .prog_end(prog_end), .done(done)
`ifdef FETCH_PERF_EN
        , .perf_bundles(perf_bundles), .perf_stall(perf_stall)
`endif
    );

    int vectors = 0, miscompares = 0;

    // Reference model: program image plus the expected visible outputs.
    logic [IW-1:0]    img [DEPTH];
    int               m_st, m_pc, m_pe, e_fpc;   // m_st: 0 idle, 1 fetching, 2 ended
    logic             e_fv, e_done;
    logic [FW*IW-1:0] e_ins;
    logic [FW-1:0]    e_sv;
    int unsigned      m_pb, m_ps;

    task automatic model_reset();
        m_st = 0; m_pc = SPC; m_pe = 0; e_fpc = 0;
        e_fv = 0; e_done = 0; e_ins = '0; e_sv = '0; m_pb = 0; m_ps = 0;
    endtask

    task automatic model_bundle(int p);
        e_ins = '0; e_sv = '0;
        for (int k = 0; k < FW; k++)
            if (p + k < m_pe) begin
                e_ins[(FW-1-k)*IW +: IW] = img[p + k];
                e_sv[FW-1-k] = 1'b1;
            end
    endtask

    task automatic model_edge();
        int prev;
        prev = m_st;
        if (e_fv && m_pb != 32'hFFFF_FFFF) m_pb++;
        if (m_st == 1 && stall && !redirect_valid && m_ps != 32'hFFFF_FFFF) m_ps++;
        case (m_st)
            0: begin
                e_fv = 0;
                if (load_en && int'(load_addr) < DEPTH) begin
                    img[load_addr] = load_data;
                    if (int'(load_addr) + 1 > m_pe) m_pe = int'(load_addr) + 1;
                end
                if (start) begin
                    m_pc = SPC; m_st = (m_pe == 0) ? 2 : 1; m_pb = 0; m_ps = 0;
                end
            end
            1: begin
                if (redirect_valid) begin
                    e_fv = 0; e_sv = '0; m_pc = int'(redirect_pc);
                    if (m_pc >= m_pe) m_st = 2;
                end else if (stall) begin
                    e_fv = 0;
                end else begin
                    e_fv = 1; e_fpc = m_pc; model_bundle(m_pc);
                    m_pc += FW;
                    if (m_pc >= m_pe) m_st = 2;
                end
            end
            default: begin
                e_fv = 0;
                if (redirect_valid) begin
                    e_sv = '0; m_pc = int'(redirect_pc);
                    if (m_pc < m_pe) m_st = 1;
                end
            end
        endcase
        e_done = (prev == 2 && m_st == 2);
    endtask

    task automatic check(string name, logic efv, int efpc, logic [FW*IW-1:0] eins,
                         logic [FW-1:0] esv, logic edn, int epe);
        vectors++;
        if (fetch_valid !== efv || fetch_pc !== AW'(efpc) || fetch_instr !== eins ||
            slot_valid !== esv || done !== edn || prog_end !== (AW+1)'(epe)) begin
            miscompares++;
            $display("FAIL %s: got fv=%b pc=%0d ins=%h sv=%b done=%b pe=%0d, want fv=%b pc=%0d ins=%h sv=%b done=%b pe=%0d",
                     name, fetch_valid, fetch_pc, fetch_instr, slot_valid, done, prog_end,
                     efv, efpc, eins, esv, edn, epe);
        end
    endtask

    task automatic expect_bit(string name, logic got, logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic step(string name);
        @(posedge clk); #1;
        model_edge();
        check(name, e_fv, e_fpc, e_ins, e_sv, e_done, m_pe);
`ifdef FETCH_PERF_EN
        vectors++;
        if (perf_bundles !== m_pb || perf_stall !== m_ps) begin
            miscompares++;
            $display("FAIL %s_perf: got bundles=%0d stall=%0d want bundles=%0d stall=%0d",
                     name, perf_bundles, perf_stall, m_pb, m_ps);
        end
`endif
    endtask

    task automatic drive(logic ld, int la, logic [IW-1:0] ldat, logic st, logic sl, logic rd, int rpc);
        load_en = ld; load_addr = AW'(la); load_data = ldat;
        start = st; stall = sl; redirect_valid = rd; redirect_pc = AW'(rpc);
    endtask

    task automatic do_reset(string name);
        drive(0, 0, '0, 0, 0, 0, 0);
        rst = 1'b1; #1;
        model_reset();
        check(name, 0, 0, '0, '0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic load_prog(int n, logic [IW-1:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1, i, base + IW'(i), 0, 0, 0, 0);
            step($sformatf("load%0d", i));
        end
        drive(0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic run_to_done(string name, output int nb);
        nb = 0;
        drive(0, 0, '0, 0, 0, 0, 0);
        for (int c = 0; c < 40 && !done; c++) begin
            step(name);
            if (fetch_valid) nb++;
        end
        expect_bit({name, "_reached_done"}, done, 1'b1);
    endtask

    typedef struct {
        logic ld; int la; logic [IW-1:0] ldat; logic st, sl, rd; int rpc;
        logic fv; int fpc; logic [FW*IW-1:0] ins; logic [FW-1:0] sv; logic dn; int pe;
    } vec_t;

    function automatic vec_t mk(logic ld, int la, logic [IW-1:0] ldat, logic st, logic sl, logic rd,
                                int rpc, logic fv, int fpc, logic [FW*IW-1:0] ins,
                                logic [FW-1:0] sv, logic dn, int pe);
        vec_t v;
        v.ld = ld; v.la = la; v.ldat = ldat; v.st = st; v.sl = sl; v.rd = rd; v.rpc = rpc;
        v.fv = fv; v.fpc = fpc; v.ins = ins; v.sv = sv; v.dn = dn; v.pe = pe;
        return v;
    endfunction

    function automatic logic [FW*IW-1:0] bw(logic [IW-1:0] a, logic [IW-1:0] b);
        return {a, b};
    endfunction

    vec_t tbl [25];

    initial begin
        int nb, len, j, t;
        int ord [32];
        logic [FW*IW-1:0] z;
        z = '0;

        for (int i = 0; i < 6; i++)
            tbl[i] = mk(1, i, 32'hA0 + i, 0, 0, 0, 0, 0, 0, z, 2'b00, 0, i + 1);
        tbl[6]  = mk(0, 0, 0, 1, 0, 0, 0,  0, 0, z, 2'b00, 0, 6);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, bw(32'hA0, 32'hA1), 2'b11, 0, 6);
        tbl[8]  = mk(0, 0, 0, 0, 1, 0, 0,  0, 0, bw(32'hA0, 32'hA1), 2'b11, 0, 6);
        tbl[9]  = tbl[8];
        tbl[10] = tbl[8];
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,  1, 2, bw(32'hA2, 32'hA3), 2'b11, 0, 6);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,  1, 4, bw(32'hA4, 32'hA5), 2'b11, 0, 6);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0,  0, 4, bw(32'hA4, 32'hA5), 2'b11, 1, 6);
        tbl[14] = mk(1, 0, 32'hDEAD, 1, 0, 0, 0, 0, 4, bw(32'hA4, 32'hA5), 2'b11, 1, 6);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 0,  0, 4, bw(32'hA4, 32'hA5), 2'b00, 0, 6);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, bw(32'hA0, 32'hA1), 2'b11, 0, 6);
        tbl[17] = mk(1, 0, 32'hDEAD, 0, 0, 0, 0, 1, 2, bw(32'hA2, 32'hA3), 2'b11, 0, 6);
        tbl[18] = mk(0, 0, 0, 0, 0, 1, 1,  0, 2, bw(32'hA2, 32'hA3), 2'b00, 0, 6);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, bw(32'hA1, 32'hA2), 2'b11, 0, 6);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0,  1, 3, bw(32'hA3, 32'hA4), 2'b11, 0, 6);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0,  1, 5, bw(32'hA5, 32'h0), 2'b10, 0, 6);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 0,  0, 5, bw(32'hA5, 32'h0), 2'b10, 1, 6);
        tbl[23] = mk(0, 0, 0, 0, 0, 1, 20, 0, 5, bw(32'hA5, 32'h0), 2'b00, 1, 6);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 0,  0, 5, bw(32'hA5, 32'h0), 2'b00, 1, 6);

        do_reset("reset_initial");
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].ld, tbl[i].la, tbl[i].ldat, tbl[i].st, tbl[i].sl, tbl[i].rd, tbl[i].rpc);
            step($sformatf("tbl_model%0d", i));
            check($sformatf("tbl_row%0d", i), tbl[i].fv, tbl[i].fpc, tbl[i].ins, tbl[i].sv, tbl[i].dn, tbl[i].pe);
        end

        // Odd-length program: last bundle is half valid.
        do_reset("reset_odd");
        load_prog(5, 32'hC0);
        drive(0, 0, '0, 1, 0, 0, 0); step("odd_start");
        run_to_done("odd_run", nb);
        vectors++;
        if (nb != 3 || fetch_pc !== AW'(4) || slot_valid !== 2'b10 || fetch_instr[IW-1:0] !== '0) begin
            miscompares++;
            $display("FAIL odd_tail: got bundles=%0d pc=%0d sv=%b slot1=%h want 3/4/10/0",
                     nb, fetch_pc, slot_valid, fetch_instr[IW-1:0]);
        end

        // Redirect beats stall, flush cycle, then target bundle.
        do_reset("reset_redir");
        load_prog(12, 32'hB0);
        drive(0, 0, '0, 1, 0, 0, 0); step("redir_start");
        drive(0, 0, '0, 0, 0, 0, 0); step("redir_b0");
        drive(0, 0, '0, 0, 1, 1, 8); step("redir_flush");
        expect_bit("redir_flush_fv", fetch_valid, 1'b0);
        drive(0, 0, '0, 0, 0, 0, 0); step("redir_target");
        expect_bit("redir_target_pc8", fetch_valid && fetch_pc == AW'(8), 1'b1);
        run_to_done("redir_run", nb);

        // Asynchronous reset mid-fetch, empty-program start, then rerun from retained memory.
        drive(0, 0, '0, 0, 0, 1, 0); step("mid_redir");
        drive(0, 0, '0, 0, 0, 0, 0); step("mid_f0");
        step("mid_f1");
        rst = 1'b1; #2;
        model_reset();
        check("reset_mid", 0, 0, '0, '0, 0, 0);
        @(posedge clk); #1; rst = 1'b0;
        drive(0, 0, '0, 1, 0, 0, 0); step("empty_start");
        drive(0, 0, '0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) step("empty_done");
        expect_bit("empty_no_fetch", fetch_valid, 1'b0);
        do_reset("reset_rerun");
        drive(1, 11, 32'hB0 + 11, 0, 0, 0, 0); step("rerun_load");
        drive(0, 0, '0, 1, 0, 0, 0); step("rerun_start");
        run_to_done("rerun", nb);
        vectors++;
        if (nb != 6) begin
            miscompares++;
            $display("FAIL rerun_count: got %0d bundles want 6", nb);
        end

        // Randomized programs, loaded out of order, with random stall/redirect traffic.
        for (int it = 0; it < 8; it++) begin
            do_reset("reset_rand");
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) ord[i] = i;
            for (int i = len - 1; i > 0; i--) begin
                j = $urandom_range(0, i); t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            for (int i = 0; i < len; i++) begin
                drive(1, ord[i], $urandom, 0, 0, 0, 0);
                step("rand_load");
            end
            drive(0, 0, '0, 1, 0, 0, 0); step("rand_start");
            for (int c = 0; c < 60; c++) begin
                drive($urandom_range(0, 9) == 0, $urandom_range(0, 40), $urandom,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 40));
                step($sformatf("rand%0d_c%0d", it, c));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
